// File: rtl/sseg_scan_decoder.sv
// Receive-side decoder for a 4-digit multiplexed seven-segment scan: filters the
// anode/cathode buses, rebuilds the 16-bit word. Optional err_cnt under SSEG_ERR_CNT_EN.
module sseg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sseg_a,
  input  logic [6:0]  sseg_c,
  output logic [15:0] value,
  output logic        valid,
  output logic [3:0]  digit_mask,
  output logic        bad,
`ifdef SSEG_ERR_CNT_EN
  output logic [7:0]  err_cnt,
`endif
  output logic        stale
);

  localparam int unsigned StW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [StW-1:0] FireCnt = StW'(STABLE_CYCLES - 2);
  localparam logic [StW-1:0] SatCnt  = StW'(STABLE_CYCLES);
  localparam logic [ToW-1:0] ToMax   = ToW'(TIMEOUT_CYCLES);

  logic [10:0]      samp_q;
  logic [StW-1:0]   stab_cnt_q, stab_cnt_d;
  logic [3:0][3:0]  nib_q, nib_d;
  logic [3:0]       mask_q, mask_d;
  logic [15:0]      value_q, value_d;
  logic             valid_q, valid_d;
  logic             bad_q, bad_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic             stale_q, stale_d;

  logic       same, fire, blank, onehot, seg_ok, capture, frame_done;
  logic [1:0] dig;
  logic [3:0] seg_nib;

  always_comb begin
    seg_ok  = 1'b1;
    seg_nib = 4'h0;
    unique case (sseg_c)
      7'h40: seg_nib = 4'h0;
      7'h79: seg_nib = 4'h1;
      7'h24: seg_nib = 4'h2;
      7'h30: seg_nib = 4'h3;
      7'h19: seg_nib = 4'h4;
      7'h12: seg_nib = 4'h5;
      7'h02: seg_nib = 4'h6;
      7'h78: seg_nib = 4'h7;
      7'h00: seg_nib = 4'h8;
      7'h10: seg_nib = 4'h9;
      7'h08: seg_nib = 4'hA;
      7'h03: seg_nib = 4'hB;
      7'h46: seg_nib = 4'hC;
      7'h21: seg_nib = 4'hD;
      7'h06: seg_nib = 4'hE;
      7'h0E: seg_nib = 4'hF;
      default: seg_ok = 1'b0;
    endcase
  end

  always_comb begin
    blank  = 1'b0;
    onehot = 1'b1;
    dig    = 2'd0;
    unique case (sseg_a)
      4'b1111: begin blank = 1'b1; onehot = 1'b0; end
      4'b1110: dig = 2'd0;
      4'b1101: dig = 2'd1;
      4'b1011: dig = 2'd2;
      4'b0111: dig = 2'd3;
      default: onehot = 1'b0;
    endcase
  end

  // Fires once per dwell: on the STABLE_CYCLES-th identical sample.
  assign same       = ({sseg_a, sseg_c} == samp_q);
  assign fire       = same && (stab_cnt_q == FireCnt);
  assign capture    = fire && onehot && seg_ok;
  assign frame_done = (mask_q == 4'hF);

  always_comb begin
    stab_cnt_d = '0;
    if (same) stab_cnt_d = (stab_cnt_q == SatCnt) ? stab_cnt_q : stab_cnt_q + StW'(1);

    bad_d   = fire && !blank && !(onehot && seg_ok);
    nib_d   = nib_q;
    mask_d  = mask_q;
    value_d = value_q;
    valid_d = 1'b0;
    if (frame_done) begin
      value_d = {nib_q[3], nib_q[2], nib_q[1], nib_q[0]};
      valid_d = 1'b1;
      mask_d  = '0;
      nib_d   = '0;
    end else if (capture) begin
      nib_d[dig]  = seg_nib;
      mask_d[dig] = 1'b1;
    end

    to_cnt_d = to_cnt_q;
    if (frame_done)             to_cnt_d = '0;
    else if (to_cnt_q != ToMax) to_cnt_d = to_cnt_q + ToW'(1);
    stale_d = (to_cnt_d == ToMax);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q     <= '1;
      stab_cnt_q <= '0;
      nib_q      <= '0;
      mask_q     <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      bad_q      <= 1'b0;
      to_cnt_q   <= '0;
      stale_q    <= 1'b0;
    end else begin
      samp_q     <= {sseg_a, sseg_c};
      stab_cnt_q <= stab_cnt_d;
      nib_q      <= nib_d;
      mask_q     <= mask_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      bad_q      <= bad_d;
      to_cnt_q   <= to_cnt_d;
      stale_q    <= stale_d;
    end
  end

`ifdef SSEG_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  always_ff @(posedge clk) begin
    if (rst)                             err_cnt_q <= '0;
    else if (bad_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end
  assign err_cnt = err_cnt_q;
`endif

  assign value      = value_q;
  assign valid      = valid_q;
  assign digit_mask = mask_q;
  assign bad        = bad_q;
  assign stale      = stale_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: scans words, glitches, bad patterns, timeout, reset.
module tb_sseg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  sseg_a = 4'hF;
  logic [6:0]  sseg_c = 7'h7F;
  logic [15:0] value;
  logic        valid;
  logic [3:0]  digit_mask;
  logic        bad;
  logic        stale;
`ifdef SSEG_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  sseg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .sseg_a     (sseg_a),
    .sseg_c     (sseg_c),
    .value      (value),
    .valid      (valid),
    .digit_mask (digit_mask),
    .bad        (bad),
`ifdef SSEG_ERR_CNT_EN
    .err_cnt    (err_cnt),
`endif
    .stale      (stale)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int bad_cnt = 0;
  int both_cnt = 0;
  logic [15:0] last_val = 16'h0;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt = valid_cnt + 1;
      last_val  = value;
    end
    if (bad) bad_cnt = bad_cnt + 1;
    if (valid && bad) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [3:0] anode(input int k);
    logic [3:0] a;
    a = 4'hF;
    a[k] = 1'b0;
    return a;
  endfunction

  task automatic drive(input logic [3:0] a, input logic [6:0] c, input int n);
    sseg_a = a;
    sseg_c = c;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic digit(input logic [15:0] w, input int k, input int n);
    drive(anode(k), seg(w[k*4 +: 4]), n);
  endtask

  task automatic scan_word(input logic [15:0] w, input int n);
    for (int k = 0; k < 4; k++) digit(w, k, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_value"}, 32'(value), 32'h0);
    check({tag, "_valid"}, 32'(valid), 32'h0);
    check({tag, "_mask"},  32'(digit_mask), 32'h0);
    check({tag, "_bad"},   32'(bad), 32'h0);
    check({tag, "_stale"}, 32'(stale), 32'h0);
  endtask

  int v0, b0;

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    check_zero("reset");

    // Normal scan of 0x1234
    v0 = valid_cnt; b0 = bad_cnt;
    scan_word(16'h1234, 32);
    drive(4'hF, 7'h7F, 4);
    check("w1234_nvalid", 32'(valid_cnt - v0), 32'd1);
    check("w1234_value", 32'(last_val), 32'h1234);
    check("w1234_nbad", 32'(bad_cnt - b0), 32'd0);
    check("w1234_mask", 32'(digit_mask), 32'h0);

    // Back-to-back 0x5678 then 0x9102
    v0 = valid_cnt;
    digit(16'h5678, 0, 128);
    digit(16'h5678, 1, 128);
    check("w5678_partial_mask", 32'(digit_mask), 32'h3);
    digit(16'h5678, 2, 128);
    digit(16'h5678, 3, 128);
    check("w5678_value", 32'(last_val), 32'h5678);
    check("w5678_mask", 32'(digit_mask), 32'h0);
    scan_word(16'h9102, 128);
    check("w9102_value", 32'(last_val), 32'h9102);
    check("w9102_mask", 32'(digit_mask), 32'h0);
    check("b2b_nvalid", 32'(valid_cnt - v0), 32'd2);

    // 3-cycle glitch inside a dwell
    v0 = valid_cnt; b0 = bad_cnt;
    digit(16'hBEEF, 0, 2);
    drive(4'b1110, 7'h7F, 3);
    digit(16'hBEEF, 0, 32);
    check("glitch_mask", 32'(digit_mask), 32'h1);
    for (int k = 1; k < 4; k++) digit(16'hBEEF, k, 32);
    drive(4'hF, 7'h7F, 4);
    check("glitch_nbad", 32'(bad_cnt - b0), 32'd0);
    check("glitch_nvalid", 32'(valid_cnt - v0), 32'd1);
    check("glitch_value", 32'(last_val), 32'hBEEF);

    // Dwell boundary: 3 identical samples do not capture, 4 do
    digit(16'h0007, 0, 3);
    drive(4'hF, 7'h7F, 4);
    check("dwell3_mask", 32'(digit_mask), 32'h0);
    digit(16'h0007, 0, 4);
    check("dwell4_mask", 32'(digit_mask), 32'h1);
    drive(4'hF, 7'h7F, 4);

    // Invalid patterns
    do_reset();
    v0 = valid_cnt; b0 = bad_cnt;
    digit(16'h4321, 0, 32);
    digit(16'h4321, 1, 32);
    drive(anode(2), 7'h7F, 32);
    drive(4'b1100, seg(4'h5), 8);
    check("inv_nbad", 32'(bad_cnt - b0), 32'd2);
    check("inv_mask", 32'(digit_mask), 32'h3);
    digit(16'h4321, 3, 32);
    check("inv_nvalid_pre", 32'(valid_cnt - v0), 32'd0);
    check("inv_mask_1011", 32'(digit_mask), 32'hB);
    digit(16'h4321, 2, 32);
    check("inv_nvalid", 32'(valid_cnt - v0), 32'd1);
    check("inv_value", 32'(last_val), 32'h4321);
`ifdef SSEG_ERR_CNT_EN
    check("inv_err_cnt", 32'(err_cnt), 32'd2);
`endif

    // Timeout: scan digits 0..2 only
    do_reset();
    v0 = valid_cnt;
    for (int r = 0; r < 10; r++)
      for (int k = 0; k < 3; k++) digit(16'h1357, k, 32);
    digit(16'h1357, 0, 63);
    check("to_stale_1023", 32'(stale), 32'h0);
    digit(16'h1357, 0, 1);
    check("to_stale_1024", 32'(stale), 32'h1);
    digit(16'h1357, 1, 32);
    digit(16'h1357, 2, 32);
    digit(16'h1357, 0, 32);
    check("to_stale_hold", 32'(stale), 32'h1);
    check("to_mask", 32'(digit_mask), 32'h7);
    check("to_nvalid_pre", 32'(valid_cnt - v0), 32'd0);
    digit(16'h1357, 3, 32);
    check("to_nvalid", 32'(valid_cnt - v0), 32'd1);
    check("to_value", 32'(last_val), 32'h1357);
    check("to_stale_clear", 32'(stale), 32'h0);

    // Reset mid-frame
    digit(16'hABCD, 0, 32);
    digit(16'hABCD, 1, 32);
    check("mid_mask_pre", 32'(digit_mask), 32'h3);
    do_reset();
    check_zero("mid_reset");
    v0 = valid_cnt;
    scan_word(16'hABCD, 32);
    drive(4'hF, 7'h7F, 4);
    check("mid_nvalid", 32'(valid_cnt - v0), 32'd1);
    check("mid_value", 32'(last_val), 32'hABCD);

    check("valid_bad_overlap", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
